// File: rtl/sirius_defs.sv
// Shared definitions for the core pipeline control logic.
//   RegBus / ZeroWord : datapath word width and its zero value
//   STALL_*           : stall vectors, bit0 PC .. bit5 WB, 1 = hold stage
//   pipe_state_t      : pipe_ctrl sequencer states
//   max2()            : elaboration-time helper for sizing counters
package sirius_defs;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  // A held stage always holds every stage before it, so only these
  // monotonic patterns are ever produced.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } pipe_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Performance counters for the pipeline sequencer (built only with
// PIPE_CTRL_PERF_EN defined).
//   clk, rst           : clock, synchronous active-high reset
//   stall_active       : some stage is held this cycle
//   flush_accept       : a flush request is accepted this cycle
//   perf_stall_cycles  : cycles with any stage held (wraps at 2^32)
//   perf_flush_count   : accepted flush requests (wraps at 2^32)
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active,
  input  logic        flush_accept,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_active) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_accept) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cycles_q;
  assign perf_flush_count  = flush_count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core: merges decode/execute
// stall requests, sequences multi-cycle EX operations (with abort on
// timeout) and drives exception/branch flushes.
//   clk, rst        : clock, synchronous active-high reset
//   stallreq_id     : load-use hazard from ID (combinational)
//   stallreq_ex     : single-cycle EX hold (combinational)
//   ex_mc_start     : EX starts a multi-cycle op this cycle
//   ex_mc_done      : EX multi-cycle result valid this cycle
//   flush_req       : exception / redirect request, flush_pc its target
//   stall[5:0]      : per-stage hold, bit0 PC .. bit5 WB (combinational)
//   flush           : clear pipeline registers to NOP (registered)
//   new_pc          : redirect target, valid while flush=1 (registered)
//   mc_cancel       : one-cycle abort pulse to the EX multi-cycle unit
//   mc_busy         : sequencer is waiting on a multi-cycle op
// Optional build macro PIPE_CTRL_PERF_EN adds perf_stall_cycles and
// perf_flush_count outputs (instance of pipe_perf_cnt).
module pipe_ctrl
  import sirius_defs::*;
#(
  parameter int MC_MAX_CYCLES = 64,
  parameter int FLUSH_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              ex_mc_start,
  input  logic              ex_mc_done,
  input  logic              flush_req,
  input  logic [RegBus-1:0] flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [RegBus-1:0] new_pc,
  output logic              mc_cancel,
  output logic              mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);

  localparam int CNT_W = $clog2(max2(MC_MAX_CYCLES, FLUSH_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  pipe_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              flush_q, flush_d;
  logic [RegBus-1:0] new_pc_q, new_pc_d;
  logic              cancel_q, cancel_d;
  logic [5:0]        stall_d;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= ZeroWord;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    cancel_d = 1'b0;
    stall_d  = STALL_NONE;

    if (flush_req) begin
      // Flush outranks everything; an in-flight multi-cycle op is aborted.
      state_d  = FLUSH;
      cnt_d    = '0;
      flush_d  = 1'b1;
      new_pc_d = flush_pc;
      cancel_d = (state_q == MC_WAIT);
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_mc_start) begin
            stall_d = STALL_EX;
            state_d = MC_WAIT;
            cnt_d   = '0;
          end else if (stallreq_ex) begin
            stall_d = STALL_EX;
          end else if (stallreq_id) begin
            stall_d = STALL_ID;
          end
        end
        MC_WAIT: begin
          cnt_d = cnt_inc;
          if (ex_mc_done) begin
            // Release the hold in the done cycle so the result advances.
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q == MC_LAST) begin
            stall_d  = STALL_EX;
            cancel_d = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
          end else begin
            stall_d = STALL_EX;
          end
        end
        FLUSH: begin
          cnt_d = cnt_inc;
          if (cnt_q == FLUSH_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            flush_d = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    if (rst) stall_d = STALL_NONE;
  end

  assign stall     = stall_d;
  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign mc_cancel = cancel_q;
  assign mc_busy   = (state_q == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .clk               (clk),
    .rst               (rst),
    .stall_active      (|stall_d),
    .flush_accept      (flush_req & ~rst),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Two instances share the stimulus:
// dut_a with default parameters, dut_b with MC_MAX_CYCLES=8 for timeout.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, ex_mc_start, ex_mc_done, flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, mc_cancel_a, mc_cancel_b, mc_busy_a, mc_busy_b;
  logic [31:0] new_pc_a, new_pc_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;
`endif

  always #5 clk = ~clk;

  pipe_ctrl dut_a (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
    .mc_cancel(mc_cancel_a), .mc_busy(mc_busy_a)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_a), .perf_flush_count(perf_flush_a)
`endif
  );

  pipe_ctrl #(.MC_MAX_CYCLES(8), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
    .mc_cancel(mc_cancel_b), .mc_busy(mc_busy_b)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_b), .perf_flush_count(perf_flush_b)
`endif
  );

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  // request bits {flush_req, ex_mc_done, ex_mc_start, stallreq_ex, stallreq_id}
  localparam logic [4:0] R_ID = 5'b00001;
  localparam logic [4:0] R_EX = 5'b00010;
  localparam logic [4:0] R_ST = 5'b00100;
  localparam logic [4:0] R_DN = 5'b01000;
  localparam logic [4:0] R_FR = 5'b10000;
  localparam logic [31:0] PC_EXC = 32'hBFC00380;

  typedef struct {
    logic        sel;   // 0 = dut_a, 1 = dut_b
    logic [40:0] v;     // {stall, flush, new_pc, mc_cancel, mc_busy}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [40:0] ev(input logic [5:0] s, input logic f,
                                     input logic [31:0] pc, input logic c,
                                     input logic b);
    return {s, f, pc, c, b};
  endfunction

  function automatic logic [40:0] obs(input logic sel);
    return sel ? {stall_b, flush_b, new_pc_b, mc_cancel_b, mc_busy_b}
               : {stall_a, flush_a, new_pc_a, mc_cancel_a, mc_busy_a};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic drive(input logic r, input logic [4:0] q, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst         = r;
    flush_req   = q[4];
    ex_mc_done  = q[3];
    ex_mc_start = q[2];
    stallreq_ex = q[1];
    stallreq_id = q[0];
    flush_pc    = pc;
  endtask

  task automatic do_reset;
    drive(1'b1, 5'b0, 32'h0);
    drive(1'b1, 5'b0, 32'h0);
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 5'b11111, 32'hFFFFFFFF);
      else       drive(1'b0, 5'b00000, 32'h0);
      exp_q.push_back('{1'b0, ev(S0, 1'b0, 32'h0, 1'b0, 1'b0)});
      exp_q.push_back('{1'b1, ev(S0, 1'b0, 32'h0, 1'b0, 1'b0)});
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.v)
          $display("FAIL reset cyc%0d dut%0d: got %h required %h", i, e.sel, obs(e.sel), e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_use;
    exp_t e;
    logic [4:0] q;
    logic [5:0] s;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q = (i == 0) ? R_ID : (i == 2) ? R_EX : (i == 3) ? (R_EX | R_ID) : (i == 4) ? R_DN : 5'b0;
      s = (i == 0) ? SI : (i == 2 || i == 3) ? SE : S0;
      drive(1'b0, q, 32'h0);
      exp_q.push_back('{1'b0, ev(s, 1'b0, 32'h0, 1'b0, 1'b0)});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL load_use cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_divide;
    exp_t e;
    logic [4:0] q;
    logic [5:0] s;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      q = (i == 0) ? R_ST : (i == 10) ? R_DN : (i == 12) ? R_ID : 5'b0;
      s = (i <= 9) ? SE : (i == 12) ? SI : S0;
      drive(1'b0, q, 32'h0);
      exp_q.push_back('{1'b0, ev(s, 1'b0, 32'h0, 1'b0, (i >= 1 && i <= 10))});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL divide cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    logic [4:0] q;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      q = (i == 0) ? R_ST : 5'b0;
      drive(1'b0, q, 32'h0);
      exp_q.push_back('{1'b1, ev((i <= 8) ? SE : S0, 1'b0, 32'h0, (i == 9), (i >= 1 && i <= 8))});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL timeout cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_done_at_timeout;
    exp_t e;
    logic [4:0] q;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q = (i == 0) ? R_ST : (i == 8) ? R_DN : 5'b0;
      drive(1'b0, q, 32'h0);
      exp_q.push_back('{1'b1, ev((i <= 7) ? SE : S0, 1'b0, 32'h0, 1'b0, (i >= 1 && i <= 8))});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL done_at_timeout cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_flush_divide;
    exp_t e;
    logic [4:0] q;
    logic [5:0] s;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q = (i == 0) ? R_ST : (i == 3) ? R_FR : (i == 4) ? R_EX : (i == 5) ? R_ID : 5'b0;
      s = (i <= 2) ? SE : (i == 5) ? SI : S0;
      drive(1'b0, q, PC_EXC);
      exp_q.push_back('{1'b0, ev(s, (i == 4), (i >= 4) ? PC_EXC : 32'h0, (i == 4),
                                 (i >= 1 && i <= 3))});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL flush_divide cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [4:0] q;
    logic [31:0] pc_exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q = (i < 2) ? R_FR : (i == 3) ? R_ID : 5'b0;
      pc_exp = (i == 0) ? 32'h0 : (i == 1) ? 32'h0000_1000 : 32'h0000_2000;
      drive(1'b0, q, (i == 0) ? 32'h0000_1000 : 32'h0000_2000);
      exp_q.push_back('{1'b0, ev((i == 3) ? SI : S0, (i == 1 || i == 2), pc_exp, 1'b0, 1'b0)});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL back_to_back cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous;
    exp_t e;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] flush_before;
`endif
    do_reset();
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    flush_before = perf_flush_a;
`endif
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0) ? (R_FR | R_EX | R_ID) : 5'b0, 32'h8000_0180);
      exp_q.push_back('{1'b0, ev(S0, (i == 1), (i == 1) ? 32'h8000_0180 : 32'h0, 1'b0, 1'b0)});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs(e.sel) !== e.v)
        $display("FAIL simultaneous cyc%0d: got %h required %h", i, obs(e.sel), e.v);
      else n_pass++;
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (perf_flush_a !== flush_before + 32'd1)
      $display("FAIL perf_flush_count: got %0d required %0d", perf_flush_a, flush_before + 32'd1);
    else n_pass++;
    n_checks++;
    if (perf_stall_a !== 32'd0)
      $display("FAIL perf_stall_cycles: got %0d required 0", perf_stall_a);
    else n_pass++;
`endif
  endtask

  initial begin
    rst         = 1'b1;
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    ex_mc_start = 1'b0;
    ex_mc_done  = 1'b0;
    flush_req   = 1'b0;
    flush_pc    = 32'h0;
    test_reset();
    test_load_use();
    test_divide();
    test_timeout();
    test_done_at_timeout();
    test_flush_divide();
    test_back_to_back();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It collects stall requests from decode and execute, and it sequences multi-cycle execute operations such as div and madd. It also drives exception/branch flushes. Its stall vector and flush outputs gate every inter-stage register, including id_ex, if_id, ex_mem and mem_wb, plus the PC register.

Parameters:
MC_MAX_CYCLES, 64, cycles allowed for a multi-cycle EX op before it is aborted (must be at least 2)
FLUSH_CYCLES, 1, number of cycles flush stays asserted after a flush request (must be at least 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
stallreq_id  input  1  decode hazard (load-use), combinational from ID
stallreq_ex  input  1  single-cycle EX hold request, combinational from EX
ex_mc_start  input  1  EX begins a multi-cycle op this cycle
ex_mc_done  input  1  EX multi-cycle result valid this cycle
flush_req  input  1  exception/redirect request
flush_pc  input  32  redirect target accompanying flush_req
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage
flush  output  1  clear all pipeline registers to NOP (registered)
new_pc  output  32  redirect target, valid while flush=1 (registered)
mc_cancel  output  1  one-cycle pulse that aborts the EX multi-cycle unit
mc_busy  output  1  state is MC_WAIT

Behaviour:
- State machine: RUN, MC_WAIT, FLUSH. Encoding comes from the shared package.
- Reset: state=RUN, cnt=0, flush=0, new_pc=0, mc_cancel=0, mc_busy=0. While rst=1, stall=6'b000000.
- stall is combinational from state and the current-cycle requests. flush, new_pc and mc_cancel are registered.
- Priority order, every state: flush_req > ex_mc_done/timeout > stallreq_ex/ex_mc_start > stallreq_id.
- flush_req=1 in any state:
  - next state FLUSH; cnt=0; flush<=1; new_pc<=flush_pc.
  - stall=0 in the request cycle.
  - If the current state is MC_WAIT, mc_cancel<=1 for one cycle.
- FLUSH state:
  - stall=0; flush stays 1; cnt increments each cycle.
  - When cnt==FLUSH_CYCLES-1: flush<=0, next state RUN.
  - A new flush_req in FLUSH restarts the count and relatches new_pc. Other requests are ignored.
- RUN state:
  - ex_mc_start=1: stall=6'b001111; next state MC_WAIT; cnt=0.
  - Otherwise stallreq_ex=1: stall=6'b001111.
  - Otherwise stallreq_id=1: stall=6'b000111.
  - Otherwise stall=0.
  - ex_mc_done in RUN is ignored.
- MC_WAIT state:
  - mc_busy=1; stall=6'b001111; cnt increments.
  - ex_mc_done=1: stall=0 in that same cycle, so the result advances; next state RUN.
  - Timeout when cnt==MC_MAX_CYCLES-1 with no done: mc_cancel<=1 pulse; stall stays 6'b001111 in that cycle; next state RUN.
  - ex_mc_done and timeout in the same cycle: done wins and there is no cancel.
- cnt width is $clog2(max(MC_MAX_CYCLES, FLUSH_CYCLES)+1). It saturates and never wraps.
- Stall vectors are monotonic: if stage k is held, all stages below k are held.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0].
  - perf_stall_cycles increments on every cycle with stall!=0. perf_flush_count increments on every accepted flush_req.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Shared package sirius_defs:
  - STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111.
  - State typedef {RUN, MC_WAIT, FLUSH}.
  - RegBus width 32 and ZeroWord.
- Sub-module: pipe_perf_cnt holds the two counters and is instantiated only under PIPE_CTRL_PERF_EN. No other sub-module.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high -> stall=0, flush=0, new_pc=0, mc_busy=0.
- Load-use: stallreq_id=1 for 1 cycle in RUN -> stall=6'b000111 that cycle, 0 the next.
- Divide: ex_mc_start at cycle t, ex_mc_done at t+10 -> stall=6'b001111 at t..t+9, 0 at t+10; mc_busy 1 at t+1..t+10; state RUN at t+11.
- Timeout: MC_MAX_CYCLES=8, ex_mc_start and no done -> mc_cancel is a single pulse 8 cycles after the MC_WAIT entry cycle; state RUN after it; stall=0 afterwards.
- Flush during divide: flush_req with flush_pc=32'hBFC00380 at the 3rd MC_WAIT cycle -> stall=0 that cycle; next cycle flush=1, new_pc=32'hBFC00380, mc_cancel=1; flush=0 after FLUSH_CYCLES.
- Simultaneous: flush_req, stallreq_ex and stallreq_id all 1 -> stall=0, flush=1 next cycle. With PIPE_CTRL_PERF_EN, perf_flush_count increments by 1.
